// File: rtl/matmul_seq.sv
// Sequential N x N unsigned 8-bit matrix multiplier: one output element per cycle, done pulse on completion.
// Optional build macro MATMUL_SAT_EN saturates each element at 8'hFF instead of truncating modulo 256.
module matmul_seq #(
    parameter int MUL_SIZE = 8,
    parameter int IDX_W    = $clog2(MUL_SIZE * MUL_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [MUL_SIZE*MUL_SIZE*8-1:0]  a,
    input  logic [MUL_SIZE*MUL_SIZE*8-1:0]  b,
    output logic                            busy,
    output logic                            done,
    output logic [MUL_SIZE*MUL_SIZE*8-1:0]  out
);
    localparam int W     = MUL_SIZE * MUL_SIZE * 8;
    localparam int ACC_W = 16 + $clog2(MUL_SIZE);
    localparam int LAST  = MUL_SIZE * MUL_SIZE - 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       out_q, out_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;

    logic [15:0]        prod;
    logic [ACC_W-1:0]   acc;
    logic [7:0]         elem;
    int                 row;
    int                 col;

    // Dot product of row `row` of A with column `col` of B; B is stored transposed so both are contiguous.
    always_comb begin
        row  = int'(idx_q) / MUL_SIZE;
        col  = int'(idx_q) % MUL_SIZE;
        prod = '0;
        acc  = '0;
        for (int m = 0; m < MUL_SIZE; m++) begin
            prod = {8'b0, a_q[(row*MUL_SIZE+m)*8 +: 8]} * {8'b0, b_q[(col*MUL_SIZE+m)*8 +: 8]};
            acc  = acc + ACC_W'(prod);
        end
`ifdef MATMUL_SAT_EN
        elem = (acc > ACC_W'(255)) ? 8'hFF : acc[7:0];
`else
        elem = acc[7:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                end
            end
            RUN: begin
                out_d[int'(idx_q)*8 +: 8] = elem;
                if (idx_q == IDX_W'(LAST)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Randomized bench for matmul_seq: matrices held as integer arrays, expected results from plain sums.
// Handshake: start is sampled only while busy=0; done is a single-cycle pulse, out valid from done onward.
module tb_matmul_seq;
    localparam int N = 8;
    localparam int W = N * N * 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] out;

    int vectors     = 0;
    int miscompares = 0;
    int ma [N][N];
    int mb [N][N];
    logic [W-1:0] exp_q[$];

    matmul_seq #(.MUL_SIZE(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_mul();
        logic [W-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int m = 0; m < N; m++) s += ma[i][m] * mb[m][j];
`ifdef MATMUL_SAT_EN
                r[(i*N+j)*8 +: 8] = (s > 255) ? 8'hFF : 8'(s);
`else
                r[(i*N+j)*8 +: 8] = 8'(s % 256);
`endif
            end
        end
        return r;
    endfunction

    task automatic rand_mats();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = $urandom_range(0, 255);
                mb[i][j] = $urandom_range(0, 255);
            end
    endtask

    task automatic fill_mats(input int va, input int vb);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = va;
                mb[i][j] = vb;
            end
    endtask

    task automatic load_inputs();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a[(i*N+j)*8 +: 8] = 8'(ma[i][j]);
                b[(j*N+i)*8 +: 8] = 8'(mb[i][j]);
            end
        exp_q.push_back(ref_mul());
    endtask

    task automatic start_run();
        load_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge right after the start edge; optional busy-time disturbance and back-to-back restart.
    task automatic run_check(input string tag, input int disturb_at, input bit b2b);
        int k = 0;
        int busy_cnt = 0;
        int done_at = -1;
        if (busy) busy_cnt++;
        while (k < 200 && done_at < 0) begin
            @(negedge clk);
            k++;
            if (disturb_at > 0 && k == disturb_at) begin
                a     = '0;
                start = 1'b1;
            end else if (disturb_at > 0 && k == disturb_at + 1) begin
                start = 1'b0;
            end
            if (done) done_at = k;
            else if (busy) busy_cnt++;
        end
        check({tag, "_done_latency"}, W'(done_at), W'(N * N));
        check({tag, "_busy_cycles"}, W'(busy_cnt), W'(N * N));
        check({tag, "_sb_depth"}, W'(exp_q.size()), W'(1));
        if (exp_q.size() > 0) check({tag, "_out"}, out, exp_q.pop_front());
        if (b2b) begin
            load_inputs();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_done_pulse_end"}, W'(done), W'(0));
            check({tag, "_b2b_accepted"}, W'(busy), W'(1));
        end else begin
            @(negedge clk);
            check({tag, "_done_pulse_end"}, W'(done), W'(0));
            check({tag, "_idle"}, W'(busy), W'(0));
        end
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int dn = 0;
        int bn = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bn++;
        end
        check({tag, "_no_done"}, W'(dn), W'(0));
        check({tag, "_no_busy"}, W'(bn), W'(0));
    endtask

    initial begin
        logic [W-1:0] direct;
        int dn;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_out", out, '0);
        rst = 1'b0;
        @(negedge clk);

        // Identity times B must reproduce B.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = (i * N + j) % 256;
            end
        start_run();
        run_check("ident", 0, 0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) direct[(i*N+j)*8 +: 8] = 8'((i * N + j) % 256);
        check("ident_eq_b", out, direct);

        fill_mats(2, 3);
        start_run();
        run_check("twos_threes", 0, 0);
        direct = {(N*N){8'(N * 6)}};
        check("twos_threes_const", out, direct);

        fill_mats(255, 255);
        start_run();
        run_check("all_ff", 0, 0);
`ifdef MATMUL_SAT_EN
        direct = {(N*N){8'hFF}};
`else
        direct = {(N*N){8'((N * 65025) % 256)}};
`endif
        check("all_ff_const", out, direct);

        rand_mats();
        start_run();
        run_check("latch", 10, 0);
        watch_quiet("latch_no_rerun", 80);

        rand_mats();
        start_run();
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_done", W'(done), W'(0));
        check("midrst_out", out, '0);
        check("midrst_early_done", W'(dn), W'(0));
        exp_q.delete();
        watch_quiet("midrst_quiet", 80);
        rand_mats();
        start_run();
        run_check("post_rst", 0, 0);

        rand_mats();
        start_run();
        rand_mats();
        run_check("b2b_first", 0, 1);
        run_check("b2b_second", 0, 0);

        repeat (4) begin
            rand_mats();
            start_run();
            run_check("random", 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequential, area-reduced replacement for the combinational 8-bit matrix multiplier in the accelerator top level.
- Consumes the same packed A and B (B pre-transposed) buses that the top-level reformatting logic drives.
- Computes one output element per cycle using MUL_SIZE parallel multipliers and an adder tree.
- Signals completion with a done pulse, so the top-level control FSM waits for done instead of a fixed single cycle.

Parameters:
- MUL_SIZE, 8: matrix dimension N (N x N, N >= 2); all elements unsigned 8-bit.
- IDX_W, $clog2(MUL_SIZE*MUL_SIZE): width of the internal element index counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request to begin a multiply; sampled at each rising edge.
- a  input  N*N*8  matrix A, row-major: a[(i*N+j)*8 +: 8] = A[i][j].
- b  input  N*N*8  matrix B, transposed: b[(j*N+i)*8 +: 8] = B[i][j].
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when out is complete.
- out  output  N*N*8  result C, row-major: out[(i*N+j)*8 +: 8] = C[i][j].

Behaviour:
- Reset: busy=0, done=0, out=0, index counter=0, latched A/B copies=0. Reset takes priority over all other activity.
- States: IDLE (busy=0), RUN (busy=1).
- IDLE -> RUN: start=1 at edge T0.
  - a and b are copied into internal registers.
  - Index counter is set to 0.
  - busy goes to 1.
  - Later changes on a/b do not affect the running computation.
- RUN, each edge Tk (k = 1..N*N): compute element e = k-1, i = e / N, j = e % N.
  - C[i][j] = sum over m of A[i][m]*B[m][j].
  - Each product is 16 bits; the accumulator is 16+$clog2(N) bits, so no overflow occurs inside the sum.
  - The value written to out is the low 8 bits (modulo 256), unless the optional feature below is enabled.
  - Only the 8-bit slice of element e updates; all other slices hold.
- RUN -> IDLE: at edge T(N*N), the last element is written, busy<=0, and done<=1.
  - done returns to 0 at the next edge.
  - Latency from the start edge to done high is exactly N*N cycles (64 for N=8).
- start while busy=1: ignored, with no restart and no queuing. This includes the final RUN cycle.
- start in the cycle where done=1: accepted, because busy is already 0.
- During RUN, out holds a mix of new and previous results. out is only valid from done until the next accepted start.
- In IDLE, out is held indefinitely.
- Reset mid-RUN: returns to IDLE with out=0. No done pulse is produced.
- All arithmetic is unsigned; there is no sign extension anywhere.

Optional Feature:
- Macro: MATMUL_SAT_EN.
- Defined: each written element saturates, so any accumulator value > 255 is written as 8'hFF. Values <= 255 are written unchanged.
- Undefined: each element is truncated to the accumulator's low 8 bits (modulo 256), matching the existing combinational multiplier.
- Timing, latency and handshake are identical in both builds.

Test Plan:
- A=identity, B[i][j]=i*8+j, start pulse:
  - busy high for exactly 64 cycles.
  - done pulses at cycle 64 after the start edge.
  - out == B, i.e. out[(i*8+j)*8+:8] == i*8+j.
- A all 0x02, B all 0x03: every element == 0x30 (8*6=48).
- A all 0xFF, B all 0xFF:
  - Without MATMUL_SAT_EN, every element == 0x08 (520200 mod 256).
  - With MATMUL_SAT_EN, every element == 0xFF.
- Input latching and start-while-busy:
  - After start, change a to all zeros and pulse start again at cycle 10.
  - Result is computed from the original A.
  - done pulses once at cycle 64.
  - No second run occurs.
- Reset mid-operation: assert rst at cycle 20 of RUN.
  - Next cycle: busy=0, done=0, out=0.
  - done never pulses.
  - A following start completes normally in 64 cycles.
- Back-to-back: assert start in the done cycle with new A/B.
  - The second run is accepted immediately.
  - done pulses 64 cycles later with the correct second result.
